// File: rtl/instr_encode_loader.sv
// Instruction encoder/loader: packs symbolic requests into 32-bit MIPS-lite
// words and streams them into instruction memory. Each word can optionally be
// read back and compared.
module instr_encode_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int VERIFY    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_shamt,
  input  logic [25:0]       req_imm,
  output logic              im_we,
  output logic              im_re,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  input  logic [31:0]       im_rdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err_illegal,
  output logic              err_verify
);

  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(1) << ADDR_W;

  typedef struct packed {
    logic [3:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [25:0] imm;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_CHECK} state_t;

  state_t            state_q, state_d;
  req_t              req;
  logic [31:0]       enc_word;
  logic              enc_legal;
  logic              live_q;     // low for the cycle(s) reset is seen, so ready rises the cycle after
  logic              clr_pend_q; // clr seen mid-transaction, applied on return to IDLE
  logic              clr_eff;
  logic              accept;
  logic              advance;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   count_q;
  logic [31:0]       word_q;
  logic              err_i_q;
  logic              err_v_q;

  assign req     = '{op: req_op, rs: req_rs, rt: req_rt, rd: req_rd,
                     shamt: req_shamt, imm: req_imm};
  assign clr_eff = clr | clr_pend_q;
  assign full    = (count_q == DEPTH_C);

  // Encode the incoming request; SRL forces rs=0 and is the only op carrying shamt.
  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    case (req.op)
      4'd0:    enc_word = {6'h00, req.rs, req.rt, req.rd, 5'd0, 6'h20};
      4'd1:    enc_word = {6'h00, req.rs, req.rt, req.rd, 5'd0, 6'h22};
      4'd2:    enc_word = {6'h00, req.rs, req.rt, req.rd, 5'd0, 6'h24};
      4'd3:    enc_word = {6'h00, req.rs, req.rt, req.rd, 5'd0, 6'h25};
      4'd4:    enc_word = {6'h00, req.rs, req.rt, req.rd, 5'd0, 6'h2A};
      4'd5:    enc_word = {6'h00, 5'd0, req.rt, req.rd, req.shamt, 6'h02};
      4'd6:    enc_word = {6'h23, req.rs, req.rt, req.imm[15:0]};
      4'd7:    enc_word = {6'h2B, req.rs, req.rt, req.imm[15:0]};
      4'd8:    enc_word = {6'h04, req.rs, req.rt, req.imm[15:0]};
      4'd9:    enc_word = {6'h0D, req.rs, req.rt, req.imm[15:0]};
      4'd10:   enc_word = {6'h1B, req.imm};
      default: enc_legal = 1'b0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and memory strobes; only IDLE accepts work, and a pending clr blocks it.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    im_we     = 1'b0;
    im_re     = 1'b0;
    accept    = 1'b0;
    advance   = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = live_q & ~full & ~clr_eff;
        accept    = req_valid & req_ready;
        if (accept && enc_legal) state_d = S_WRITE;
      end
      S_WRITE: begin
        im_we = 1'b1;
        if (VERIFY != 0) state_d = S_READ;
        else begin
          state_d = S_IDLE;
          advance = 1'b1;
        end
      end
      S_READ: begin
        im_re   = 1'b1;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        state_d = S_IDLE;
        advance = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: latched word, address/count, sticky errors and deferred clr.
  always_ff @(posedge clk) begin
    if (reset) begin
      live_q     <= 1'b0;
      addr_q     <= BASE;
      count_q    <= '0;
      word_q     <= '0;
      err_i_q    <= 1'b0;
      err_v_q    <= 1'b0;
      clr_pend_q <= 1'b0;
    end else begin
      live_q <= 1'b1;
      if (state_q == S_IDLE) begin
        if (clr_eff) begin
          addr_q     <= BASE;
          count_q    <= '0;
          err_i_q    <= 1'b0;
          err_v_q    <= 1'b0;
          clr_pend_q <= 1'b0;
        end else if (accept) begin
          if (enc_legal) word_q  <= enc_word;
          else           err_i_q <= 1'b1;
        end
      end else if (clr) begin
        clr_pend_q <= 1'b1;
      end
      if (advance) begin
        addr_q  <= addr_q + ADDR_W'(1);
        count_q <= count_q + (ADDR_W+1)'(1);
      end
      if (state_q == S_CHECK && im_rdata != word_q) err_v_q <= 1'b1;
    end
  end

  assign im_addr     = addr_q;
  assign im_wdata    = word_q;
  assign count       = count_q;
  assign err_illegal = err_i_q;
  assign err_verify  = err_v_q;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Scoreboard bench for instr_encode_loader with a small instruction memory
// model that can corrupt bit 0 on readback.
module tb_instr_encode_loader;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int BASE   = 5;

  logic              clk = 1'b0;
  logic              reset, clr, req_valid, req_ready;
  logic [3:0]        req_op;
  logic [4:0]        req_rs, req_rt, req_rd, req_shamt;
  logic [25:0]       req_imm;
  logic              im_we, im_re;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata, im_rdata;
  logic [ADDR_W:0]   count;
  logic              full, err_illegal, err_verify;

  instr_encode_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .VERIFY(1)) dut (
    .clk(clk), .reset(reset), .clr(clr), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
    .req_shamt(req_shamt), .req_imm(req_imm), .im_we(im_we), .im_re(im_re),
    .im_addr(im_addr), .im_wdata(im_wdata), .im_rdata(im_rdata), .count(count),
    .full(full), .err_illegal(err_illegal), .err_verify(err_verify));

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       word;
  } exp_t;

  exp_t              sb[$];
  int                n_chk = 0, n_fail = 0;
  logic [ADDR_W-1:0] exp_addr;
  int                exp_count;
  bit                exp_ill, exp_ver;
  bit                corrupt = 1'b0;
  logic [ADDR_W-1:0] last_waddr = '0;
  logic [31:0]       mem [DEPTH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference encoding computed from field positions with plain arithmetic.
  function automatic logic [31:0] ref_word(int op, int rs, int rt, int rd, int sh, int imm);
    longint w;
    int     fn, opc;
    fn = 0; opc = 0;
    case (op)
      0: fn = 'h20;  1: fn = 'h22;  2: fn = 'h24;
      3: fn = 'h25;  4: fn = 'h2A;  5: fn = 'h02;
      6: opc = 'h23; 7: opc = 'h2B; 8: opc = 'h04; 9: opc = 'h0D;
      default: opc = 'h1B;
    endcase
    if (op < 6)
      w = longint'(op == 5 ? 0 : rs) * (1 << 21) + longint'(rt) * (1 << 16) +
          longint'(rd) * (1 << 11) + longint'(op == 5 ? sh : 0) * 64 + fn;
    else if (op < 10)
      w = longint'(opc) * (1 << 26) + longint'(rs) * (1 << 21) +
          longint'(rt) * (1 << 16) + (imm % 65536);
    else
      w = longint'(opc) * (1 << 26) + (imm % (1 << 26));
    return w[31:0];
  endfunction

  // Memory model: writes land at the edge, reads return one cycle after im_re.
  always @(posedge clk) begin
    if (im_we) mem[im_addr] <= im_wdata;
    if (im_re) im_rdata <= mem[im_addr] ^ {31'b0, corrupt};
  end

  // Monitor: every write must match the oldest expected entry; reads hit the last written address.
  always @(negedge clk) begin
    if (im_we) begin
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_write: addr %h data %h with empty scoreboard", im_addr, im_wdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("we_addr", 32'(im_addr), 32'(e.addr));
        check("we_data", im_wdata, e.word);
        last_waddr = e.addr;
      end
    end
    if (im_re) check("re_addr", 32'(im_addr), 32'(last_waddr));
  end

  task automatic send(input int op, input int rs, input int rt, input int rd, input int sh,
                      input int imm, input logic [31:0] exp_w, input bit use_exp);
    int n;
    exp_t e;
    @(negedge clk);
    req_op = 4'(op); req_rs = 5'(rs); req_rt = 5'(rt); req_rd = 5'(rd);
    req_shamt = 5'(sh); req_imm = 26'(imm); req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      n_chk++; n_fail++;
      $display("FAIL ready_timeout: req_ready stayed 0 for %0d cycles", n);
      req_valid = 1'b0;
    end else begin
      if (op <= 10) begin
        e.addr = exp_addr;
        e.word = use_exp ? exp_w : ref_word(op, rs, rt, rd, sh, imm);
        sb.push_back(e);
        exp_addr = exp_addr + 1'b1;
        exp_count++;
      end else begin
        exp_ill = 1'b1;
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
    end
  endtask

  task automatic check_state(input string tag);
    repeat (5) @(negedge clk);
    check({tag, "_count"}, 32'(count), 32'(exp_count));
    check({tag, "_addr"}, 32'(im_addr), 32'(exp_addr));
    check({tag, "_full"}, 32'(full), 32'(exp_count == DEPTH));
    check({tag, "_ready"}, 32'(req_ready), 32'(exp_count < DEPTH));
    check({tag, "_err_ill"}, 32'(err_illegal), 32'(exp_ill));
    check({tag, "_err_ver"}, 32'(err_verify), 32'(exp_ver));
  endtask

  task automatic model_clear();
    exp_addr = ADDR_W'(BASE); exp_count = 0; exp_ill = 1'b0; exp_ver = 1'b0;
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    model_clear();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(req_ready), 0);
    check({tag, "_we"}, 32'(im_we), 0);
    check({tag, "_re"}, 32'(im_re), 0);
    check({tag, "_addr"}, 32'(im_addr), BASE);
    check({tag, "_wdata"}, im_wdata, 0);
    check({tag, "_count"}, 32'(count), 0);
    check({tag, "_full"}, 32'(full), 0);
    check({tag, "_errs"}, {30'b0, err_illegal, err_verify}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; clr = 1'b0; req_valid = 1'b0; req_op = '0; req_rs = '0; req_rt = '0;
    req_rd = '0; req_shamt = '0; req_imm = '0;
    model_clear();
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready_after", 32'(req_ready), 1);

    // Directed encodings; unused fields carry junk that must be ignored.
    send(0, 1, 2, 3, 9, 26'h3FFFFFF, 32'h00221820, 1);  check_state("add");
    send(5, 7, 5, 4, 2, 26'h1234,    32'h00052082, 1);  check_state("srl");
    send(6, 0, 8, 7, 3, 26'h3FF0004, 32'h8C080004, 1);  check_state("lw");
    send(8, 1, 2, 0, 0, 16'hFFFF,    32'h1022FFFF, 1);  check_state("beq_wrap");
    send(10, 31, 31, 0, 0, 26'h10,   32'h6C000010, 1);  check_state("baln");
    send(15, 1, 2, 3, 0, 0, 32'h0, 0);                  check_state("illegal");
    send(7, 3, 4, 0, 0, 26'h0ABCD, 32'h0, 0);           check_state("sw_after_ill");

    // Readback corruption must flag err_verify yet still count the word.
    corrupt = 1'b1;
    send(9, 2, 6, 0, 0, 16'h8001, 32'h0, 0);
    exp_ver = 1'b1;
    check_state("verify_err");
    corrupt = 1'b0;

    do_clr();
    check_state("clr");

    // clr during WRITE is deferred; the transaction completes first.
    send(1, 4, 5, 6, 0, 0, 32'h0, 0);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    repeat (3) @(negedge clk);
    check("clr_pend_count", 32'(count), 32'(exp_count));
    check("clr_pend_ready", 32'(req_ready), 0);
    model_clear();
    check_state("clr_pend_done");

    // clr and valid together: clr wins, nothing is accepted.
    @(negedge clk);
    req_op = 4'd0; req_valid = 1'b1; clr = 1'b1;
    #1 check("clr_vs_req_ready", 32'(req_ready), 0);
    @(posedge clk);
    #1 begin clr = 1'b0; req_valid = 1'b0; end
    model_clear();
    check_state("clr_vs_req");

    // Random fill until full, with illegal ops mixed in.
    while (exp_count < DEPTH)
      send($urandom_range(0, 12), $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, (1 << 26) - 1),
           32'h0, 0);
    check_state("full");
    @(negedge clk);
    req_op = 4'd2; req_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("full_blocks_ready", 32'(req_ready), 0);
    req_valid = 1'b0;
    do_clr();
    check_state("clr_after_full");

    // Reset during READ aborts: no CHECK, outputs at reset values next cycle.
    send(3, 1, 1, 1, 0, 0, 32'h0, 0);
    n = 0;
    @(negedge clk);
    while (!im_re && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("reach_read", 32'(im_re), 1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    check("rst_mid_no_check_re", 32'(im_re), 0);
    check("rst_mid_ready", 32'(req_ready), 1);
    check_state("rst_mid_idle");

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
